mau_unit: RTL and testbench

- Memory access unit. Sits directly upstream of the write stage and produces its mau_en / mau_dst / mau_out inputs.
- Accepts one load/store from issue and runs it on a 16-bit word memory bus with a req/ack handshake.
- Returns load results and holds each one until the write stage actually consumes it. The write stage gives ALU results priority and would otherwise drop a MAU result in a cycle where alu_en is high.

---
 rtl/mau_unit.sv | 137 +++++++++++++
 tb/tb_mau_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mau_unit.sv
// rtl/mau_unit.sv - memory access unit: one load/store on a 16-bit word bus, result held for the write stage
module mau_unit #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_op,
    input  logic [3:0]  issue_dst,
    input  logic [15:0] issue_addr,
    input  logic [15:0] issue_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        alu_en,
    output logic        mau_en,
    output logic [3:0]  mau_dst,
    output logic [15:0] mau_out,
    output logic        mau_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last cycle of the request window; a disabled timeout never compares true
    localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = TO_LAST_I[CNT_W-1:0];
    localparam logic             TO_EN    = (TIMEOUT != 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cap_dst;
    logic             cap_store;
    logic             cap_lsb;

    logic             issue_word;
    logic             issue_misaligned;

    // Only the handshake flag is combinational so issue sees readiness without a bubble
    assign issue_ready      = (state == IDLE);
    assign issue_word       = ~issue_op[1];
    assign issue_misaligned = issue_word & issue_addr[0];

    // Transaction sequencer with registered bus and result outputs
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_dst   <= '0;
            cap_store <= 1'b0;
            cap_lsb   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            mau_en    <= 1'b0;
            mau_dst   <= '0;
            mau_out   <= '0;
            mau_err   <= 1'b0;
        end else begin
            mau_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        cap_dst   <= issue_dst;
                        cap_store <= issue_op[0];
                        cap_lsb   <= issue_addr[0];
                        if (issue_misaligned) begin
                            mau_err <= 1'b1;
                        end else begin
                            state    <= REQ;
                            cnt      <= '0;
                            mem_req  <= 1'b1;
                            mem_we   <= issue_op[0];
                            mem_addr <= issue_addr[15:1];
                            if (issue_word)
                                mem_be <= 2'b11;
                            else
                                mem_be <= issue_addr[0] ? 2'b10 : 2'b01;
                            case (issue_op)
                                2'b01:   mem_wdata <= issue_data;
                                2'b11:   mem_wdata <= {issue_data[7:0], issue_data[7:0]};
                                default: mem_wdata <= '0;
                            endcase
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (cap_store) begin
                            state <= IDLE;
                        end else begin
                            state   <= RESP;
                            mau_en  <= 1'b1;
                            mau_dst <= cap_dst;
                            // Word loads return the full word; byte loads zero-extend the addressed lane
                            if (mem_be == 2'b11)
                                mau_out <= mem_rdata;
                            else
                                mau_out <= {8'h00, cap_lsb ? mem_rdata[15:8] : mem_rdata[7:0]};
                        end
                    end else if (TO_EN && (cnt == TO_LAST)) begin
                        mem_req <= 1'b0;
                        mau_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // The write stage drops our result while the ALU owns it, so wait for a free cycle
                    if (!alu_en) begin
                        mau_en <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mau_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mau_unit.sv
// tb/tb_mau_unit.sv - directed self-checking bench for mau_unit
module tb_mau_unit;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  issue_op;
    logic [3:0]  issue_dst;
    logic [15:0] issue_addr;
    logic [15:0] issue_data;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        alu_en;
    logic        mau_en;
    logic [3:0]  mau_dst;
    logic [15:0] mau_out;
    logic        mau_err;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    mau_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_dst   (issue_dst),
        .issue_addr  (issue_addr),
        .issue_data  (issue_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .alu_en      (alu_en),
        .mau_en      (mau_en),
        .mau_dst     (mau_dst),
        .mau_out     (mau_out),
        .mau_err     (mau_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [3:0] dst,
                         input logic [15:0] data);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_addr  = addr;
        issue_dst   = dst;
        issue_data  = data;
        tick();
        issue_valid = 1'b0;
    endtask

    initial begin
        cpu_rst     = 1'b1;
        issue_valid = 1'b0;
        issue_op    = 2'b00;
        issue_dst   = 4'h0;
        issue_addr  = 16'h0000;
        issue_data  = 16'h0000;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        alu_en      = 1'b0;
        tick();
        tick();
        cpu_rst = 1'b0;
        chk("rst_ready", issue_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_en", mau_en, 0);
        chk("rst_err", mau_err, 0);

        // Reset in the middle of a request
        issue(2'b00, 16'h0010, 4'd3, 16'h0000);
        chk("midreq_req", mem_req, 1);
        #2 cpu_rst = 1'b1;
        #1;
        chk("async_req_drop", mem_req, 0);
        chk("async_ready", issue_ready, 1);
        tick();
        cpu_rst = 1'b0;
        tick();
        chk("post_rst_ready", issue_ready, 1);
        chk("post_rst_en", mau_en, 0);
        chk("post_rst_err", mau_err, 0);

        // LW zero wait
        issue(2'b00, 16'h0010, 4'd3, 16'h0000);
        chk("lw_req", mem_req, 1);
        chk("lw_we", mem_we, 0);
        chk("lw_addr", mem_addr, 15'h0008);
        chk("lw_be", mem_be, 2'b11);
        chk("lw_wdata", mem_wdata, 16'h0000);
        chk("lw_busy", issue_ready, 0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        chk("lw_req_fall", mem_req, 0);
        chk("lw_en", mau_en, 1);
        chk("lw_dst", mau_dst, 4'd3);
        chk("lw_out", mau_out, 16'hBEEF);
        chk("lw_ready_low", issue_ready, 0);
        tick();
        chk("lw_en_done", mau_en, 0);
        chk("lw_ready_back", issue_ready, 1);

        // LB high byte with three wait cycles and ALU contention
        issue(2'b10, 16'h0021, 4'd5, 16'h0000);
        chk("lb_be", mem_be, 2'b10);
        chk("lb_addr", mem_addr, 15'h0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lb_wait_req", mem_req, 1);
            chk("lb_wait_be", mem_be, 2'b10);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'h5A77;
        alu_en    = 1'b1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'hFFFF;
        chk("lb_en1", mau_en, 1);
        chk("lb_out1", mau_out, 16'h005A);
        chk("lb_dst1", mau_dst, 4'd5);
        tick();
        chk("lb_en2", mau_en, 1);
        chk("lb_out2", mau_out, 16'h005A);
        chk("lb_dst2", mau_dst, 4'd5);
        tick();
        alu_en = 1'b0;
        chk("lb_en3", mau_en, 1);
        chk("lb_out3", mau_out, 16'h005A);
        chk("lb_ready3", issue_ready, 0);
        tick();
        chk("lb_en_done", mau_en, 0);
        chk("lb_ready_back", issue_ready, 1);

        // SB then SW back to back
        issue(2'b11, 16'h0041, 4'd0, 16'h12CD);
        chk("sb_we", mem_we, 1);
        chk("sb_be", mem_be, 2'b10);
        chk("sb_wdata", mem_wdata, 16'hCDCD);
        chk("sb_addr", mem_addr, 15'h0020);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sb_req_fall", mem_req, 0);
        chk("sb_no_en", mau_en, 0);
        chk("sb_ready", issue_ready, 1);
        issue(2'b01, 16'h0040, 4'd0, 16'hA5A5);
        chk("sw_we", mem_we, 1);
        chk("sw_be", mem_be, 2'b11);
        chk("sw_wdata", mem_wdata, 16'hA5A5);
        chk("sw_addr", mem_addr, 15'h0020);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sw_no_en", mau_en, 0);
        chk("sw_ready", issue_ready, 1);

        // Misaligned word load
        issue(2'b00, 16'h0003, 4'd2, 16'h0000);
        chk("mis_req", mem_req, 0);
        chk("mis_err", mau_err, 1);
        chk("mis_en", mau_en, 0);
        chk("mis_ready", issue_ready, 1);
        tick();
        chk("mis_err_pulse", mau_err, 0);
        chk("mis_en2", mau_en, 0);
        chk("mis_req2", mem_req, 0);

        // Timeout with no ack
        issue(2'b10, 16'h0100, 4'd6, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", mem_req, 1);
            chk("to_no_err", mau_err, 0);
            tick();
        end
        chk("to_req_drop", mem_req, 0);
        chk("to_err", mau_err, 1);
        chk("to_en", mau_en, 0);
        chk("to_ready", issue_ready, 1);
        tick();
        chk("to_err_pulse", mau_err, 0);
        chk("to_en2", mau_en, 0);

        // Ack on the last allowed cycle wins over the timeout
        issue(2'b00, 16'h0200, 4'd7, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("late_req_high", mem_req, 1);
            tick();
        end
        chk("late_req_4th", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        chk("late_en", mau_en, 1);
        chk("late_err", mau_err, 0);
        chk("late_out", mau_out, 16'h1234);
        chk("late_dst", mau_dst, 4'd7);
        tick();
        chk("late_en_done", mau_en, 0);
        chk("late_err2", mau_err, 0);
        chk("late_ready", issue_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
